// File: rtl/mebx_onchip_mem_byte_writer_pkg.sv
// Shared types and defaults for the on-chip memory byte writer.
package mebx_onchip_mem_byte_writer_pkg;

  localparam int MEM_DEPTH_DEF = 229376;
  localparam int ADDR_W_DEF    = 18;
  localparam int CNT_W_DEF     = 20;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Number of populated byte lanes in a 4-lane word.
  function automatic logic [2:0] popcount4(input logic [3:0] be);
    popcount4 = 3'(be[0]) + 3'(be[1]) + 3'(be[2]) + 3'(be[3]);
  endfunction

endpackage

// File: rtl/mebx_onchip_mem_byte_writer_if.sv
// Command, byte-stream, memory and status signals of the byte writer.
interface mebx_onchip_mem_byte_writer_if
  import mebx_onchip_mem_byte_writer_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [CNT_W-1:0]  cmd_bytes;
  logic              snk_valid;
  logic              snk_ready;
  logic [7:0]        snk_data;
  logic              snk_eop;
  logic [ADDR_W-1:0] mem_address;
  logic [3:0]        mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [31:0]       mem_writedata;
  logic              busy;
  logic              done;
  logic              overflow;
  logic [CNT_W-1:0]  bytes_written;

  modport slave (
    input  cmd_valid, cmd_addr, cmd_bytes, snk_valid, snk_data, snk_eop,
    output cmd_ready, snk_ready, mem_address, mem_byteenable, mem_chipselect,
           mem_write, mem_writedata, busy, done, overflow, bytes_written
  );

  modport master (
    output cmd_valid, cmd_addr, cmd_bytes, snk_valid, snk_data, snk_eop,
    input  cmd_ready, snk_ready, mem_address, mem_byteenable, mem_chipselect,
           mem_write, mem_writedata, busy, done, overflow, bytes_written
  );
endinterface

// File: rtl/mebx_onchip_mem_byte_writer_packer.sv
// Packs stream bytes little-endian into a 32-bit word with per-lane enables.
module mebx_byte_lane_packer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clr,
  input  logic        load,
  input  logic [7:0]  byte_in,
  output logic [31:0] data,
  output logic [3:0]  be,
  output logic        lane_last
);
  logic [1:0]  lane_r;
  logic [31:0] data_r;
  logic [3:0]  be_r;

  // Lane counter, data and enables: cleared after each word, filled per byte.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lane_r <= 2'd0;
      data_r <= 32'd0;
      be_r   <= 4'd0;
    end else if (clr) begin
      lane_r <= 2'd0;
      data_r <= 32'd0;
      be_r   <= 4'd0;
    end else if (load) begin
      data_r[{lane_r, 3'b000} +: 8] <= byte_in;
      be_r[lane_r]                  <= 1'b1;
      lane_r                        <= lane_r + 2'd1;
    end else begin
      lane_r <= lane_r;
      data_r <= data_r;
      be_r   <= be_r;
    end
  end

  assign data      = data_r;
  assign be        = be_r;
  assign lane_last = (lane_r == 2'd3);
endmodule

// File: rtl/mebx_onchip_mem_byte_writer.sv
// Collects a byte stream into 32-bit words and writes them to on-chip memory.
module mebx_onchip_mem_byte_writer
  import mebx_onchip_mem_byte_writer_pkg::*;
#(
  parameter int MEM_DEPTH = MEM_DEPTH_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input logic clk,
  input logic reset_n,
  mebx_onchip_mem_byte_writer_if.slave bus
);
  state_t            state_r;
  state_t            state_nxt_s;
  logic [ADDR_W-1:0] addr_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              end_r;
  logic [CNT_W-1:0]  bytes_written_r;
  logic              overflow_r;
  logic              cmd_ready_r;
  logic              snk_ready_r;
  logic              mem_write_r;
  logic              busy_r;
  logic              done_r;
  logic              cmd_acc_s;
  logic              byte_acc_s;
  logic              oob_s;
  logic [31:0]       addr_ext_s;
  logic [31:0]       pk_data_s;
  logic [3:0]        pk_be_s;
  logic              pk_last_s;

  assign cmd_acc_s  = bus.cmd_valid & cmd_ready_r;
  assign byte_acc_s = bus.snk_valid & snk_ready_r;
  // Compare at 32 bits so a depth that does not fit ADDR_W still works.
  assign addr_ext_s = 32'(addr_r);
  assign oob_s      = (addr_ext_s >= 32'(MEM_DEPTH));

  mebx_byte_lane_packer u_packer (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr       (state_r == WRITE),
    .load      (byte_acc_s),
    .byte_in   (bus.snk_data),
    .data      (pk_data_s),
    .be        (pk_be_s),
    .lane_last (pk_last_s)
  );

  // Next-state decode for the transfer sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (cmd_acc_s) begin
          if (bus.cmd_bytes == {CNT_W{1'b0}}) state_nxt_s = DONE;
          else                               state_nxt_s = COLLECT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      COLLECT: begin
        if (byte_acc_s && (pk_last_s || (cnt_r == CNT_W'(1)) || bus.snk_eop)) begin
          state_nxt_s = WRITE;
        end else begin
          state_nxt_s = COLLECT;
        end
      end
      WRITE: begin
        if (end_r) state_nxt_s = DONE;
        else       state_nxt_s = COLLECT;
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register and handshake/strobe outputs registered from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      cmd_ready_r <= 1'b0;
      snk_ready_r <= 1'b0;
      mem_write_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cmd_ready_r <= (state_nxt_s == IDLE);
      snk_ready_r <= (state_nxt_s == COLLECT);
      mem_write_r <= (state_nxt_s == WRITE) && !oob_s;
      busy_r      <= (state_nxt_s != IDLE);
      done_r      <= (state_nxt_s == DONE);
    end
  end

  // Word address: latched on accept, advanced after each word, parked at 0 when idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_r <= {ADDR_W{1'b0}};
    end else if (cmd_acc_s) begin
      addr_r <= bus.cmd_addr;
    end else if (state_r == WRITE) begin
      // Saturate so an out-of-range transfer can never wrap onto address 0.
      if (addr_r != {ADDR_W{1'b1}}) addr_r <= addr_r + ADDR_W'(1);
      else                          addr_r <= addr_r;
    end else if (state_r == DONE) begin
      addr_r <= {ADDR_W{1'b0}};
    end else begin
      addr_r <= addr_r;
    end
  end

  // Remaining byte count and end-of-transfer flag (count exhausted or eop seen).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= {CNT_W{1'b0}};
      end_r <= 1'b0;
    end else if (cmd_acc_s) begin
      cnt_r <= bus.cmd_bytes;
      end_r <= 1'b0;
    end else if (byte_acc_s) begin
      cnt_r <= cnt_r - CNT_W'(1);
      end_r <= (cnt_r == CNT_W'(1)) || bus.snk_eop;
    end else begin
      cnt_r <= cnt_r;
      end_r <= end_r;
    end
  end

  // Committed-byte counter and sticky overflow flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bytes_written_r <= {CNT_W{1'b0}};
      overflow_r      <= 1'b0;
    end else if (cmd_acc_s) begin
      bytes_written_r <= {CNT_W{1'b0}};
      overflow_r      <= 1'b0;
    end else begin
      if (state_r == WRITE && mem_write_r) begin
        bytes_written_r <= bytes_written_r + CNT_W'(popcount4(pk_be_s));
      end else begin
        bytes_written_r <= bytes_written_r;
      end
      if (state_r == COLLECT && state_nxt_s == WRITE && oob_s) overflow_r <= 1'b1;
      else                                                     overflow_r <= overflow_r;
    end
  end

  assign bus.cmd_ready      = cmd_ready_r;
  assign bus.snk_ready      = snk_ready_r;
  assign bus.mem_address    = addr_r;
  assign bus.mem_byteenable = pk_be_s;
  assign bus.mem_writedata  = pk_data_s;
  assign bus.mem_chipselect = mem_write_r;
  assign bus.mem_write      = mem_write_r;
  assign bus.busy           = busy_r;
  assign bus.done           = done_r;
  assign bus.overflow       = overflow_r;
  assign bus.bytes_written  = bytes_written_r;
endmodule

// File: doc/mebx_onchip_mem_byte_writer.md
MEBX_ONCHIP_MEM_BYTE_WRITER -- requirements
Module: mebx_onchip_mem_byte_writer

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 229376, number of 32-bit words in the target memory.
REQ-002 SHALL have parameter ADDR_W, default 18, word-address width.
REQ-003 SHALL have parameter CNT_W, default 20, byte-count width.
REQ-004 clk  in  1  single clock; all logic is on its rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 cmd_valid  in  1  command present.
REQ-007 cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high.
REQ-008 cmd_addr  in  ADDR_W  start word address.
REQ-009 cmd_bytes  in  CNT_W  number of bytes to transfer.
REQ-010 snk_valid  in  1  stream byte present.
REQ-011 snk_ready  out  1  byte accepted when snk_valid and snk_ready are both high.
REQ-012 snk_data  in  8  stream byte.
REQ-013 snk_eop  in  1  marks the last byte of a packet.
REQ-014 mem_address  out  ADDR_W  memory word address.
REQ-015 mem_byteenable  out  4  memory byte lanes.
REQ-016 mem_chipselect  out  1  memory select.
REQ-017 mem_write  out  1  memory write strobe.
REQ-018 mem_writedata  out  32  memory write data.
REQ-019 busy  out  1  high from command accept until done.
REQ-020 done  out  1  one-cycle pulse at end of transfer.
REQ-021 overflow  out  1  sticky; cleared on the next command accept.
REQ-022 bytes_written  out  CNT_W  count of bytes actually committed to memory in the current or most recent transfer.

Function
REQ-023 SHALL implement a state machine with states IDLE, COLLECT, WRITE and DONE.
REQ-024 IDLE: cmd_ready=1; on accept, latch address and count, clear bytes_written and overflow, and go to COLLECT; if cmd_bytes=0, go to DONE instead.
REQ-025 COLLECT: snk_ready=1; byte k (0..3) of each word SHALL be placed little-endian in writedata[8k+7:8k] with byteenable bit k set.
REQ-026 COLLECT SHALL go to WRITE when lane 3 fills, when the remaining count reaches 0, or when a byte arrives with snk_eop=1.
REQ-027 WRITE SHALL hold for exactly one cycle with mem_chipselect=mem_write=1, snk_ready=0, and byteenable showing only the filled lanes.
REQ-028 The memory has no waitrequest; each write SHALL complete in its WRITE cycle.
REQ-029 After WRITE: increment the address and add the popcount of byteenable to bytes_written; go to DONE if the transfer has ended, otherwise return to COLLECT with all lanes empty.
REQ-030 DONE SHALL hold one cycle with done=1, then return to IDLE.
REQ-031 An eop byte SHALL terminate the transfer even if the count is not exhausted; bytes beyond the count are not accepted.
REQ-032 If a write address is at or above MEM_DEPTH: suppress the write (chipselect=write=0), set overflow, and keep consuming bytes without writing until count or eop ends the transfer.
REQ-033 The address SHALL never wrap to 0.
REQ-034 A cmd_addr at or above MEM_DEPTH SHALL cause overflow on the first word.
REQ-035 Throughput SHALL be 4 bytes per 5 cycles under continuous snk_valid.
REQ-036 The write for the last byte SHALL occur the cycle after that byte is accepted; done SHALL follow one cycle later.
REQ-037 When idle, mem_* outputs SHALL be 0.

Reset
REQ-038 On reset_n low, asynchronously: state=IDLE; cmd_ready=0 until the first clock edge after release; snk_ready, mem_chipselect, mem_write, busy, done and overflow =0; mem_address, mem_byteenable, mem_writedata and bytes_written =0.
REQ-039 A reset mid-transfer SHALL discard any partial word without writing it.

Structure
REQ-040 A shared package SHALL hold the state enum and the MEM_DEPTH/ADDR_W/CNT_W defaults.
REQ-041 One sub-module, mebx_byte_lane_packer, SHALL contain the lane counter, data and byteenable registers.
REQ-042 The state machine and address/count logic SHALL stay in the top module.

Verification
REQ-043 cmd addr=0x10, bytes=8, bytes 01..08 -> two writes: addr 0x10 data 0x04030201 be 0xF; addr 0x11 data 0x08070605 be 0xF; then done, bytes_written=8.
REQ-044 cmd bytes=6, bytes AA..FF -> second write at addr+1 with be 0x3, data[15:0]=0xFFEE; bytes_written=6.
REQ-045 cmd bytes=100, eop on the 3rd byte -> one write with be 0x7; done; bytes_written=3; snk_ready=0 after the eop byte.
REQ-046 cmd addr=229375, bytes=8 -> write at 229375; second word suppressed; overflow=1; bytes_written=4.
REQ-047 cmd bytes=0 -> done pulse the cycle after accept; no mem_write.
REQ-048 reset_n pulsed low after 2 of 4 bytes -> no write occurs; all outputs at reset values; a subsequent command operates normally.
